fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter bits SHALL default to 8: data word width, legal range 5..9, matches the source FIFO width.
REQ-002 Parameter baud_div SHALL default to 16: clock cycles per serial bit, legal range >= 2.
REQ-003 Parameter stop_bits SHALL default to 1: stop bit count, legal values 1 or 2.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Port fifo_not_empty SHALL be an input, 1 bit: look-ahead word valid from the source FIFO.
REQ-007 Port data_in SHALL be an input, bits wide: the look-ahead FIFO word, valid while fifo_not_empty is high.
REQ-008 Port tx_ena SHALL be an input, 1 bit: permits starting new frames.
REQ-009 Port shift_out SHALL be an output, 1 bit: one-cycle pop pulse to the FIFO.
REQ-010 Port tx SHALL be an output, 1 bit: registered serial line, idle high.
REQ-011 Port busy SHALL be an output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-013 A pop SHALL occur in any cycle where the FSM is in IDLE or in the final STOP cycle, with fifo_not_empty=1, tx_ena=1 and reset=0.
- On a pop: shift_out=1 for that cycle only, data_in latched into the shift register, next state START.
REQ-014 shift_out SHALL never be high while fifo_not_empty=0, and SHALL be high for at most one cycle per frame.
REQ-015 data_in SHALL be sampled only in the pop cycle; later changes SHALL NOT affect the frame in flight.
REQ-016 tx SHALL go low on the clock edge that ends the pop cycle (1-cycle latency), and each bit SHALL last exactly baud_div cycles.
REQ-017 Frame order SHALL be: start 0, then bits data bits LSB first, then [parity], then stop_bits x baud_div cycles of 1.
REQ-018 Baud counter SHALL count baud_div-1 down to 0, reloading on every bit boundary; the bit counter SHALL be $clog2(bits+1) wide.
REQ-019 When a pop occurs in the final STOP cycle, the next frame SHALL start with no idle gap; otherwise the next state SHALL be IDLE.
REQ-020 When tx_ena is deasserted mid-frame, the current frame SHALL complete and no new pop SHALL occur.
REQ-021 In IDLE, tx SHALL be 1.

Reset
REQ-022 While reset=1 at a clock edge, the next state SHALL be: state=IDLE, tx=1, busy=0, shift_out=0, counters=0, shift register=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, and no pop SHALL occur during any cycle in which reset=1.

Configuration
REQ-024 With macro FIFO_UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and transmit even parity (XOR of the data bits) for baud_div cycles.
REQ-025 Without FIFO_UART_TX_PARITY_EN, PARITY SHALL be absent and STOP SHALL directly follow the last data bit.

Verification (bits=8, baud_div=4, stop_bits=1)
REQ-026 Single word: fifo_not_empty=1 for one cycle with data_in=0xA5 -> one shift_out pulse; tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; busy high for 40 cycles.
REQ-027 Back-to-back: FIFO holds 0x00 then 0xFF, fifo_not_empty held high -> two shift_out pulses exactly 40 cycles apart; tx shows 80 contiguous frame cycles with no idle gap.
REQ-028 Parity (macro on): data_in=0x07 -> parity bit=1 after bit 7; frame length 44 cycles.
REQ-029 tx_ena dropped at cycle 12 of a frame with the FIFO still non-empty -> frame completes at cycle 40; no further shift_out; tx stays 1.
REQ-030 Reset at cycle 10 of a frame, then idle -> tx=1, busy=0, shift_out=0 from the next cycle; a pop resumes only after reset is released.
REQ-031 fifo_not_empty=0 for 100 cycles with tx_ena=1 -> tx=1, busy=0 and shift_out=0 throughout.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a look-ahead FIFO and serialises them as start, data (LSB first), optional parity and stop bits.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
module fifo_uart_tx #(
    parameter int bits      = 8,
    parameter int baud_div  = 16,
    parameter int stop_bits = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_not_empty,
    input  logic [bits-1:0] data_in,
    input  logic            tx_ena,
    output logic            shift_out,
    output logic            tx,
    output logic            busy
);

    localparam int BAUD_W = $clog2(baud_div);
    localparam int BIT_W  = $clog2(bits + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(baud_div - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(bits - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(stop_bits - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity_bit;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [bits-1:0]   shreg;
    logic              bit_end;
    logic              last_stop;
    logic              pop;

    assign bit_end   = (baud_cnt == '0);
    assign last_stop = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);

    // The pop must coincide with the cycle the FIFO word is consumed, so it is
    // decoded from the current state and inputs rather than registered.
    assign pop       = !reset && tx_ena && fifo_not_empty && ((state == IDLE) || last_stop);
    assign shift_out = pop;

    // NOTE: every register here uses <= so all state advances together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
            shreg    <= data_in;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
        end else if (state == IDLE) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else if (!bit_end) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
        end else begin
            baud_cnt <= BAUD_LAST;
            case (state)
                START: begin
                    state   <= DATA;
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == DATA_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= parity_bit;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    state   <= STOP;
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                end
`endif
                STOP: begin
                    // Final stop cycle without a pop falls back to IDLE.
                    if (bit_cnt == STOP_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a frame-level reference model predicts pops and the tx/busy waveform cycle by cycle.
module tb_fifo_uart_tx;

    localparam int BITS  = 8;
    localparam int BAUD  = 4;
    localparam int STOPB = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_BITS = 1 + BITS + PAR + STOPB;
    localparam int FRAME_CYC  = FRAME_BITS * BAUD;

    logic            clk = 1'b0;
    logic            reset;
    logic            fifo_not_empty;
    logic [BITS-1:0] data_in;
    logic            tx_ena;
    logic            shift_out;
    logic            tx;
    logic            busy;

    fifo_uart_tx #(.bits(BITS), .baud_div(BAUD), .stop_bits(STOPB)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_not_empty (fifo_not_empty),
        .data_in        (data_in),
        .tx_ena         (tx_ena),
        .shift_out      (shift_out),
        .tx             (tx),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [BITS-1:0] fifo_q[$];
    int              pops[$];
    int              pos = -1;       // cycle index within the current frame, -1 when idle
    logic [15:0]     frame = '1;
    int              cyc = 0;
    int              busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] make_frame(input logic [BITS-1:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < BITS; i++) f[1+i] = d[i];
        if (PAR == 1) f[1+BITS] = ^d;
        return f;
    endfunction

    // One clock: drive at the falling edge, check the pop, advance the model, check tx/busy.
    task automatic cycle(input logic rst, input logic ena, input logic avail);
        logic exp_pop;
        logic exp_tx;
        reset          = rst;
        tx_ena         = ena;
        fifo_not_empty = avail && (fifo_q.size() > 0);
        data_in        = fifo_not_empty ? fifo_q[0] : BITS'($urandom);
        #1;
        exp_pop = !rst && ena && fifo_not_empty && (pos < 0 || pos == FRAME_CYC - 1);
        check("shift_out", 32'(shift_out), 32'(exp_pop));
        if (rst) begin
            pos = -1;
        end else if (exp_pop) begin
            frame = make_frame(fifo_q.pop_front());
            pos   = 0;
            pops.push_back(cyc);
        end else if (pos >= 0) begin
            pos++;
            if (pos == FRAME_CYC) pos = -1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_tx = (pos < 0) ? 1'b1 : frame[pos / BAUD];
        check("tx", 32'(tx), 32'(exp_tx));
        check("busy", 32'(busy), 32'(pos >= 0));
        if (busy) busy_cnt++;
    endtask

    initial begin
        int gap;
        reset          = 1'b1;
        tx_ena         = 1'b1;
        fifo_not_empty = 1'b0;
        data_in        = '0;
        @(negedge clk);

        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        // Empty FIFO for 100 cycles with transmit enabled.
        busy_cnt = 0;
        repeat (100) cycle(1'b0, 1'b1, 1'b1);
        check("empty_busy_cycles", 32'(busy_cnt), 32'd0);
        check("empty_pops", 32'(pops.size()), 32'd0);

        // Single word 0xA5.
        fifo_q.push_back(8'hA5);
        busy_cnt = 0;
        repeat (FRAME_CYC + 8) cycle(1'b0, 1'b1, 1'b1);
        check("single_pops", 32'(pops.size()), 32'd1);
        check("single_busy_len", 32'(busy_cnt), 32'(FRAME_CYC));

        // Single word 0x07 (odd number of ones).
        fifo_q.push_back(8'h07);
        busy_cnt = 0;
        repeat (FRAME_CYC + 8) cycle(1'b0, 1'b1, 1'b1);
        check("w07_busy_len", 32'(busy_cnt), 32'(FRAME_CYC));

        // Back-to-back 0x00 then 0xFF.
        pops.delete();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        busy_cnt = 0;
        repeat (2 * FRAME_CYC + 8) cycle(1'b0, 1'b1, 1'b1);
        gap = (pops.size() >= 2) ? pops[1] - pops[0] : -1;
        check("b2b_pops", 32'(pops.size()), 32'd2);
        check("b2b_gap", 32'(gap), 32'(FRAME_CYC));
        check("b2b_busy_len", 32'(busy_cnt), 32'(2 * FRAME_CYC));

        // tx_ena dropped at frame cycle 12 with a word still waiting.
        pops.delete();
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'hC3);
        repeat (12) cycle(1'b0, 1'b1, 1'b1);
        repeat (60) cycle(1'b0, 1'b0, 1'b1);
        check("ena_off_pops", 32'(pops.size()), 32'd1);
        check("ena_off_left", 32'(fifo_q.size()), 32'd1);
        check("ena_off_tx", 32'(tx), 32'd1);
        repeat (FRAME_CYC + 4) cycle(1'b0, 1'b1, 1'b1);
        check("ena_on_drained", 32'(fifo_q.size()), 32'd0);

        // Reset at frame cycle 10 with another word pending.
        pops.delete();
        fifo_q.push_back(8'h5A);
        repeat (10) cycle(1'b0, 1'b1, 1'b1);
        fifo_q.push_back(8'h66);
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        check("rst_abort_pops", 32'(pops.size()), 32'd1);
        check("rst_abort_busy", 32'(busy), 32'd0);
        cycle(1'b0, 1'b1, 1'b1);
        check("rst_resume_pops", 32'(pops.size()), 32'd2);
        repeat (FRAME_CYC + 4) cycle(1'b0, 1'b1, 1'b1);

        // Random traffic, enable gating, FIFO stalls and occasional resets.
        repeat (3000) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 99) < 15)
                fifo_q.push_back(BITS'($urandom));
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 7) != 0);
        end
        repeat (FRAME_CYC * 6) cycle(1'b0, 1'b1, 1'b1);
        check("random_drained", 32'(fifo_q.size()), 32'd0);
        check("random_idle_tx", 32'(tx), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
